// File: rtl/fact_bcd_conv.sv
// fact_bcd_conv: sequential double-dabble binary-to-packed-BCD converter for the factorial result
// Ports: clk (rising edge), rst (async, active-low), start/bin/err_in (request, sampled in IDLE),
//        busy (conversion running), done (one-cycle update pulse), err (status of last request),
//        bcd (packed BCD result, digit 0 in bits [3:0], held between conversions)
module fact_bcd_conv #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  err_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    state_t              r_state, w_next;
    logic [WIDTH-1:0]    r_sr;
    logic [4*DIGITS-1:0] r_acc, w_adj, w_acc_next;
    logic [CW-1:0]       r_cnt;
    logic                w_last;
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = r_acc[4*d +: 4] >= 4'd5 ? r_acc[4*d +: 4] + 4'd3 : r_acc[4*d +: 4];
    end
    // shift the adjusted accumulator left, pulling in the next binary bit
    assign w_acc_next = (w_adj << 1) | (4*DIGITS)'(r_sr[WIDTH-1]);
    assign w_last     = r_cnt == CW'(WIDTH - 1);
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:    w_next = start ? (err_in ? FIN : SHIFT) : IDLE;
            SHIFT: begin
                busy   = 1'b1;
                w_next = w_last ? FIN : SHIFT;
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            bcd   <= '0;
            err   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            if (err_in) begin
                bcd <= '1;
                err <= 1'b1;
            end else begin
                r_sr  <= bin;
                r_acc <= '0;
                r_cnt <= '0;
            end
        end else if (r_state == SHIFT) begin
            r_sr  <= r_sr << 1;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                bcd <= w_acc_next;
                err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fact_bcd_conv.sv
// tb_fact_bcd_conv: self-checking bench for fact_bcd_conv (table vectors, random vs. arithmetic model, corner sequences)
module tb_fact_bcd_conv;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] bin = '0;
    logic        err_in = 1'b0;
    logic        busy, done, err;
    logic [39:0] bcd;
    int          n_pass = 0;
    int          n_total = 0;

    fact_bcd_conv dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin    (bin),
        .err_in (err_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .bcd    (bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic        e;
        logic [39:0] exp_bcd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // decimal digits by plain division
    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        longint x = longint'(v);
        logic [39:0] r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // one request; lat = edges after the accepting edge until done is seen, busy_n = cycles busy
    task automatic convert(input logic [31:0] b, input logic e, input bit disturb,
                           output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1; bin = b; err_in = e;
        @(posedge clk);
        lat = -1;
        busy_n = 0;
        for (int j = 0; j < 100 && lat < 0; j++) begin
            @(negedge clk);
            if (j == 0) start = 1'b0;
            if (disturb) begin
                if (j == 2) begin start = 1'b1; bin = 32'd5040; err_in = 1'b1; end
                if (j == 4) begin start = 1'b0; bin = $urandom; end
                if (j == 6) start = 1'b1;
                if (j == 7) begin start = 1'b0; err_in = 1'b0; end
            end
            if (busy) busy_n++;
            if (done) lat = j;
        end
        if (lat < 0) chk("done_timeout", 64'(lat), 64'd32);
        @(negedge clk);
        chk("done_single_pulse", 64'(done), 64'd0);
    endtask

    vec_t tbl[7];
    int   lat, bn;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'd120,        1'b0, 40'h0000000120, 1'b0};
        tbl[1] = '{32'd479001600,  1'b0, 40'h0479001600, 1'b0};
        tbl[2] = '{32'hFFFFFFFF,   1'b0, 40'h4294967295, 1'b0};
        tbl[3] = '{32'd0,          1'b0, 40'h0000000000, 1'b0};
        tbl[4] = '{32'd12345,      1'b1, 40'hFFFFFFFFFF, 1'b1};
        tbl[5] = '{32'd5040,       1'b0, 40'h0000005040, 1'b0};
        tbl[6] = '{32'd3628800,    1'b0, 40'h0003628800, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err",  64'(err),  64'd0);
        chk("reset_bcd",  64'(bcd),  64'd0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            convert(tbl[i].b, tbl[i].e, 1'b0, lat, bn);
            chk("tbl_bcd",     64'(bcd), 64'(tbl[i].exp_bcd));
            chk("tbl_err",     64'(err), 64'(tbl[i].exp_err));
            chk("tbl_latency", 64'(lat), tbl[i].e ? 64'd0 : 64'd32);
            chk("tbl_busy",    64'(bn),  tbl[i].e ? 64'd0 : 64'd32);
        end

        for (int i = 0; i < 20; i++) begin
            logic [31:0] b;
            logic        e;
            b = $urandom;
            if (i % 4 == 0) b = b >> $urandom_range(0, 31);
            e = $urandom_range(0, 7) == 0;
            convert(b, e, 1'b0, lat, bn);
            chk("rnd_bcd",     64'(bcd), e ? 64'hFF_FFFF_FFFF : 64'(to_bcd(b)));
            chk("rnd_err",     64'(err), 64'(e));
            chk("rnd_latency", 64'(lat), e ? 64'd0 : 64'd32);
        end

        // start/bin/err_in activity during a conversion must be ignored
        convert(32'd720, 1'b0, 1'b1, lat, bn);
        chk("ign_bcd",     64'(bcd), 64'h0000000720);
        chk("ign_err",     64'(err), 64'd0);
        chk("ign_latency", 64'(lat), 64'd32);
        chk("ign_busy",    64'(bn),  64'd32);

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1; bin = 32'd4321; err_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_err",  64'(err),  64'd0);
        chk("async_bcd",  64'(bcd),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 64'({busy, done}), 64'd0);
        chk("post_reset_bcd",  64'(bcd), 64'd0);
        convert(32'd24, 1'b0, 1'b0, lat, bn);
        chk("post_reset_conv", 64'(bcd), 64'h0000000024);
        chk("post_reset_lat",  64'(lat), 64'd32);

        // start held high: back-to-back conversions every WIDTH+2 cycles
        begin
            int t[$];
            int bad_stable = 0;
            int bad_pulse = 0;
            logic prev_done = 1'b0;
            @(negedge clk);
            start = 1'b1; bin = 32'd1; err_in = 1'b0;
            for (int c = 0; c < 110; c++) begin
                @(negedge clk);
                if (done) begin
                    if (prev_done) bad_pulse++;
                    t.push_back(c);
                end
                if (t.size() > 0 && bcd !== 40'h0000000001) bad_stable++;
                prev_done = done;
            end
            start = 1'b0;
            chk("b2b_pulses", 64'(t.size()), 64'd3);
            if (t.size() >= 3) begin
                chk("b2b_period1", 64'(t[1] - t[0]), 64'd34);
                chk("b2b_period2", 64'(t[2] - t[1]), 64'd34);
            end
            chk("b2b_single", 64'(bad_pulse),  64'd0);
            chk("b2b_stable", 64'(bad_stable), 64'd0);
            for (int c = 0; c < 50 && (busy || done); c++) @(negedge clk);
            chk("b2b_idle", 64'({busy, done}), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
